// File: rtl/pll_ctrl_pkg.sv
// Shared types and constants for the EHXPLLL dynamic phase-shift controller.
package pll_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SETUP     = 3'd1,
        ST_STEP_LO   = 3'd2,
        ST_STEP_HI   = 3'd3,
        ST_LOAD      = 3'd4,
        ST_WAIT_LOCK = 3'd5,
        ST_RESP      = 3'd6
    } state_e;

    // PHASESEL encoding of the PLL outputs
    localparam logic [1:0] CH_CLKOP  = 2'd0;
    localparam logic [1:0] CH_CLKOS  = 2'd1;
    localparam logic [1:0] CH_CLKOS2 = 2'd2;
    localparam logic [1:0] CH_CLKOS3 = 2'd3;

    // PHASEDIR encoding: advance increments the phase, retard decrements it
    localparam logic DIR_ADV = 1'b0;
    localparam logic DIR_RET = 1'b1;

endpackage

// File: rtl/pll_dynphase_ctrl_sync2.sv
// Two-flop synchroniser for the asynchronous PLL lock indication.
module sync2 (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two-stage capture; both stages clear on reset so lock reads low afterwards
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_dynphase_ctrl.sv
// Dynamic phase-shift sequencer for the ECP5 EHXPLLL: accepts absolute phase
// requests per output, steps along the shortest path, loads and waits for lock.
module pll_dynphase_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int NUM_CH       = 3,
    parameter int PHASE_MOD    = 48,
    parameter int PHASE_W      = 6,
    parameter int SETUP_CYC    = 2,
    parameter int STEP_HOLD    = 4,
    parameter int SETTLE_CYC   = 8,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic                      clock,
    input  logic                      resetn,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [1:0]                req_ch,
    input  logic [PHASE_W-1:0]        req_phase,
    output logic                      done,
    output logic                      error,
    output logic                      busy,
    output logic [NUM_CH*PHASE_W-1:0] phase_q,
    input  logic                      pll_lock,
    output logic [1:0]                pll_phasesel,
    output logic                      pll_phasedir,
    output logic                      pll_phasestep,
    output logic                      pll_phaseloadreg
);

    // One extra bit so (target + PHASE_MOD - cur) cannot overflow
    localparam int CW    = PHASE_W + 1;
    localparam int CNT_W = $clog2(LOCK_TIMEOUT + SETUP_CYC + STEP_HOLD + SETTLE_CYC + 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]      steps_q, steps_d;
    logic [1:0]         ch_q, ch_d;
    logic [1:0]         sel_q, sel_d;
    logic               dir_q, dir_d;
    logic               step_q, step_d;
    logic               load_q, load_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               error_q, error_d;
    logic [PHASE_W-1:0] phase_arr_q [NUM_CH];
    logic [PHASE_W-1:0] phase_arr_d [NUM_CH];

    logic               lock_s;
    logic [PHASE_W-1:0] cur_phase;
    logic [CW-1:0]      tgt_ext, cur_ext, fwd;
    logic               ch_ok, ph_ok;

    sync2 u_lock_sync (
        .clk_i  (clock),
        .rst_ni (resetn),
        .d_i    (pll_lock),
        .q_o    (lock_s)
    );

    // Shortest-path evaluation of the presented request against the current phase
    always_comb begin
        cur_phase = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (req_ch == 2'(i)) cur_phase = phase_arr_q[i];
        end
        ch_ok   = int'(req_ch) < NUM_CH;
        ph_ok   = int'(req_phase) < PHASE_MOD;
        tgt_ext = {1'b0, req_phase};
        cur_ext = {1'b0, cur_phase};
        if (tgt_ext >= cur_ext) fwd = tgt_ext - cur_ext;
        else                    fwd = tgt_ext + CW'(PHASE_MOD) - cur_ext;
    end

    // Next-state, sequencing counters and registered PLL port values
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        steps_d     = steps_q;
        ch_d        = ch_q;
        sel_d       = sel_q;
        dir_d       = dir_q;
        done_d      = 1'b0;
        error_d     = 1'b0;
        phase_arr_d = phase_arr_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && ready_q) begin
                    if (!ch_ok || !ph_ok || !lock_s) begin
                        error_d = 1'b1;
                        state_d = ST_RESP;
                    end else if (fwd == '0) begin
                        done_d  = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        ch_d  = req_ch;
                        sel_d = req_ch;
                        cnt_d = '0;
                        if (fwd <= CW'(PHASE_MOD / 2)) begin
                            dir_d   = DIR_ADV;
                            steps_d = fwd;
                        end else begin
                            dir_d   = DIR_RET;
                            steps_d = CW'(PHASE_MOD) - fwd;
                        end
                        state_d = ST_SETUP;
                    end
                end
            end
            ST_SETUP: begin
                if (cnt_q == CNT_W'(SETUP_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_STEP_LO;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_STEP_LO: begin
                if (cnt_q == CNT_W'(STEP_HOLD - 1)) begin
                    cnt_d   = '0;
                    steps_d = steps_q - CW'(1);
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (ch_q == 2'(i)) begin
                            if (dir_q == DIR_ADV)
                                phase_arr_d[i] = (phase_arr_q[i] == PHASE_W'(PHASE_MOD - 1))
                                                 ? '0 : phase_arr_q[i] + PHASE_W'(1);
                            else
                                phase_arr_d[i] = (phase_arr_q[i] == '0)
                                                 ? PHASE_W'(PHASE_MOD - 1) : phase_arr_q[i] - PHASE_W'(1);
                        end
                    end
                    state_d = ST_STEP_HI;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_STEP_HI: begin
                if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = (steps_q != '0) ? ST_STEP_LO : ST_LOAD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_LOAD: begin
                if (cnt_q == CNT_W'(STEP_HOLD - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT_LOCK;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    error_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Pulses and status follow the next state so they line up with it exactly
        step_d  = (state_d != ST_STEP_LO);
        load_d  = (state_d != ST_LOAD);
        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d != ST_IDLE) && (state_d != ST_RESP);
    end

    // State and output registers; everything clears so the PLL port pins go idle at once
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            steps_q     <= '0;
            ch_q        <= CH_CLKOP;
            sel_q       <= CH_CLKOP;
            dir_q       <= DIR_RET;
            step_q      <= 1'b1;
            load_q      <= 1'b1;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            phase_arr_q <= '{default: '0};
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            steps_q     <= steps_d;
            ch_q        <= ch_d;
            sel_q       <= sel_d;
            dir_q       <= dir_d;
            step_q      <= step_d;
            load_q      <= load_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            phase_arr_q <= phase_arr_d;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_phase_out
        assign phase_q[g*PHASE_W +: PHASE_W] = phase_arr_q[g];
    end

    assign req_ready        = ready_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign error            = error_q;
    assign pll_phasesel     = sel_q;
    assign pll_phasedir     = dir_q;
    assign pll_phasestep    = step_q;
    assign pll_phaseloadreg = load_q;

endmodule

// File: tb/tb_pll_dynphase_ctrl.sv
// Directed bench for pll_dynphase_ctrl: vector table of requests plus hand-written
// lock-timeout, lock-low rejection and mid-step reset sequences.
module tb_pll_dynphase_ctrl;

    localparam int NUM_CH       = 3;
    localparam int PHASE_W      = 6;
    localparam int STEP_HOLD    = 4;
    localparam int LOCK_TIMEOUT = 65535;

    logic                      clock = 1'b0;
    logic                      resetn;
    logic                      req_valid;
    logic                      req_ready;
    logic [1:0]                req_ch;
    logic [PHASE_W-1:0]        req_phase;
    logic                      done;
    logic                      error;
    logic                      busy;
    logic [NUM_CH*PHASE_W-1:0] phase_q;
    logic                      pll_lock;
    logic [1:0]                pll_phasesel;
    logic                      pll_phasedir;
    logic                      pll_phasestep;
    logic                      pll_phaseloadreg;

    pll_dynphase_ctrl dut (
        .clock            (clock),
        .resetn           (resetn),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_ch           (req_ch),
        .req_phase        (req_phase),
        .done             (done),
        .error            (error),
        .busy             (busy),
        .phase_q          (phase_q),
        .pll_lock         (pll_lock),
        .pll_phasesel     (pll_phasesel),
        .pll_phasedir     (pll_phasedir),
        .pll_phasestep    (pll_phasestep),
        .pll_phaseloadreg (pll_phaseloadreg)
    );

    always #5 clock = ~clock;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Pulse monitor: counts step/load pulses, flags wrong widths, select/dir
    // changes while a pulse is low, and done/error overlap
    int   n_step = 0, n_load = 0, n_bad = 0;
    int   run_s = 0, run_l = 0;
    logic prev_s = 1'b1, prev_l = 1'b1, prev_dir = 1'b1;
    logic [1:0] prev_sel = 2'd0;

    always @(negedge clock) begin
        if (!resetn) begin
            run_s = 0; run_l = 0; prev_s = 1'b1; prev_l = 1'b1;
        end else begin
            if (!pll_phasestep) begin
                if (prev_s) n_step++;
                run_s++;
            end else begin
                if (!prev_s && run_s != STEP_HOLD) n_bad++;
                run_s = 0;
            end
            if (!pll_phaseloadreg) begin
                if (prev_l) n_load++;
                run_l++;
            end else begin
                if (!prev_l && run_l != STEP_HOLD) n_bad++;
                run_l = 0;
            end
            if ((!pll_phasestep || !pll_phaseloadreg || !prev_s || !prev_l) &&
                (pll_phasesel != prev_sel || pll_phasedir != prev_dir)) n_bad++;
            if (done && error) n_bad++;
            prev_s = pll_phasestep;
            prev_l = pll_phaseloadreg;
        end
        prev_sel = pll_phasesel;
        prev_dir = pll_phasedir;
    end

    // Present one request, deassert after acceptance, count cycles to done/error
    task automatic do_req(input logic [1:0] ch, input logic [PHASE_W-1:0] ph, input int budget,
                          output int lat, output logic got_done, output logic got_err);
        int w;
        @(negedge clock);
        req_valid = 1'b1;
        req_ch    = ch;
        req_phase = ph;
        w = 0;
        while (!req_ready && w < 50) begin
            @(negedge clock);
            w++;
        end
        @(negedge clock);
        req_valid = 1'b0;
        lat = 1;
        while (!(done || error) && lat < budget) begin
            @(negedge clock);
            lat++;
        end
        got_done = done;
        got_err  = error;
    endtask

    typedef struct {
        logic [1:0]                ch;
        logic [PHASE_W-1:0]        ph;
        logic                      exp_done;
        logic                      exp_err;
        int                        exp_lat;
        int                        exp_pulses;
        int                        exp_loads;
        logic [1:0]                exp_sel;
        logic                      exp_dir;
        logic [NUM_CH*PHASE_W-1:0] exp_pq;
    } vec_t;

    vec_t vt[10];

    initial begin
        #(95000 * 10);
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "time limit");
    end

    initial begin
        int   lat, s0, l0, b0;
        logic gd, ge;

        // Expected latency of a move of s steps with lock present: 8 + 12*s cycles
        vt[0] = '{2'd1, 6'd5,  1'b1, 1'b0, 68,  5,  1, 2'd1, 1'b0, {6'd0,  6'd5, 6'd0}};
        vt[1] = '{2'd0, 6'd2,  1'b1, 1'b0, 32,  2,  1, 2'd0, 1'b0, {6'd0,  6'd5, 6'd2}};
        vt[2] = '{2'd0, 6'd46, 1'b1, 1'b0, 56,  4,  1, 2'd0, 1'b1, {6'd0,  6'd5, 6'd46}};
        vt[3] = '{2'd2, 6'd24, 1'b1, 1'b0, 296, 24, 1, 2'd2, 1'b0, {6'd24, 6'd5, 6'd46}};
        vt[4] = '{2'd2, 6'd24, 1'b1, 1'b0, 1,   0,  0, 2'd2, 1'b0, {6'd24, 6'd5, 6'd46}};
        vt[5] = '{2'd3, 6'd10, 1'b0, 1'b1, 1,   0,  0, 2'd2, 1'b0, {6'd24, 6'd5, 6'd46}};
        vt[6] = '{2'd0, 6'd50, 1'b0, 1'b1, 1,   0,  0, 2'd2, 1'b0, {6'd24, 6'd5, 6'd46}};
        vt[7] = '{2'd0, 6'd47, 1'b1, 1'b0, 20,  1,  1, 2'd0, 1'b0, {6'd24, 6'd5, 6'd47}};
        vt[8] = '{2'd0, 6'd0,  1'b1, 1'b0, 20,  1,  1, 2'd0, 1'b0, {6'd24, 6'd5, 6'd0}};
        vt[9] = '{2'd2, 6'd1,  1'b1, 1'b0, 284, 23, 1, 2'd2, 1'b1, {6'd1,  6'd5, 6'd0}};

        resetn    = 1'b0;
        pll_lock  = 1'b1;
        req_valid = 1'b0;
        req_ch    = 2'd0;
        req_phase = '0;

        repeat (3) @(negedge clock);
        check("rst_ready",   {31'd0, req_ready},        32'd0);
        check("rst_done",    {31'd0, done},             32'd0);
        check("rst_error",   {31'd0, error},            32'd0);
        check("rst_busy",    {31'd0, busy},             32'd0);
        check("rst_phase_q", {14'd0, phase_q},          32'd0);
        check("rst_sel",     {30'd0, pll_phasesel},     32'd0);
        check("rst_dir",     {31'd0, pll_phasedir},     32'd1);
        check("rst_step",    {31'd0, pll_phasestep},    32'd1);
        check("rst_load",    {31'd0, pll_phaseloadreg}, 32'd1);

        resetn = 1'b1;
        @(posedge clock); #1;
        check("rel_ready", {31'd0, req_ready}, 32'd1);
        repeat (3) @(negedge clock);

        for (int i = 0; i < 10; i++) begin
            s0 = n_step; l0 = n_load; b0 = n_bad;
            do_req(vt[i].ch, vt[i].ph, 400, lat, gd, ge);
            check($sformatf("v%0d_done", i),  {31'd0, gd}, {31'd0, vt[i].exp_done});
            check($sformatf("v%0d_error", i), {31'd0, ge}, {31'd0, vt[i].exp_err});
            check($sformatf("v%0d_lat", i),   lat, vt[i].exp_lat);
            repeat (2) @(negedge clock);
            check($sformatf("v%0d_pulses", i), n_step - s0, vt[i].exp_pulses);
            check($sformatf("v%0d_loads", i),  n_load - l0, vt[i].exp_loads);
            check($sformatf("v%0d_bad", i),    n_bad - b0, 32'd0);
            check($sformatf("v%0d_sel", i),    {30'd0, pll_phasesel}, {30'd0, vt[i].exp_sel});
            check($sformatf("v%0d_dir", i),    {31'd0, pll_phasedir}, {31'd0, vt[i].exp_dir});
            check($sformatf("v%0d_phase_q", i), {14'd0, phase_q}, {14'd0, vt[i].exp_pq});
            check($sformatf("v%0d_busy", i),   {31'd0, busy}, 32'd0);
            check($sformatf("v%0d_ready", i),  {31'd0, req_ready}, 32'd1);
        end

        // Lock timeout: ch1 5 -> 7 (2 steps), lock dropped right after acceptance
        s0 = n_step; l0 = n_load;
        @(negedge clock);
        req_valid = 1'b1; req_ch = 2'd1; req_phase = 6'd7;
        @(negedge clock);
        req_valid = 1'b0;
        pll_lock  = 1'b0;
        lat = 1;
        while (!(done || error) && lat < 70000) begin
            @(negedge clock);
            lat++;
        end
        check("to_error",   {31'd0, error}, 32'd1);
        check("to_done",    {31'd0, done},  32'd0);
        check("to_lat",     lat, 7 + 12 * 2 + LOCK_TIMEOUT);
        repeat (2) @(negedge clock);
        check("to_pulses",  n_step - s0, 32'd2);
        check("to_loads",   n_load - l0, 32'd1);
        check("to_phase_q", {14'd0, phase_q}, {14'd0, 6'd1, 6'd7, 6'd0});
        check("to_busy",    {31'd0, busy}, 32'd0);

        // Lock still low: request is rejected with no PLL activity
        s0 = n_step;
        do_req(2'd0, 6'd5, 50, lat, gd, ge);
        check("nolock_error", {31'd0, ge}, 32'd1);
        check("nolock_lat",   lat, 32'd1);
        repeat (2) @(negedge clock);
        check("nolock_pulses", n_step - s0, 32'd0);
        check("nolock_phase_q", {14'd0, phase_q}, {14'd0, 6'd1, 6'd7, 6'd0});
        pll_lock = 1'b1;
        repeat (3) @(negedge clock);

        // Reset in the middle of a PHASESTEP low pulse
        @(negedge clock);
        req_valid = 1'b1; req_ch = 2'd0; req_phase = 6'd10;
        @(negedge clock);
        req_valid = 1'b0;
        lat = 0;
        while (pll_phasestep && lat < 20) begin
            @(negedge clock);
            lat++;
        end
        check("mid_step_low", {31'd0, pll_phasestep}, 32'd0);
        #2 resetn = 1'b0;
        #1;
        check("mid_rst_step",    {31'd0, pll_phasestep},    32'd1);
        check("mid_rst_load",    {31'd0, pll_phaseloadreg}, 32'd1);
        check("mid_rst_busy",    {31'd0, busy},             32'd0);
        check("mid_rst_ready",   {31'd0, req_ready},        32'd0);
        check("mid_rst_phase_q", {14'd0, phase_q},          32'd0);
        check("mid_rst_dir",     {31'd0, pll_phasedir},     32'd1);
        @(negedge clock);
        resetn = 1'b1;
        @(posedge clock); #1;
        check("mid_rel_ready",   {31'd0, req_ready}, 32'd1);
        check("mid_rel_phase_q", {14'd0, phase_q},   32'd0);
        check("mid_rel_step",    {31'd0, pll_phasestep}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
